// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: sync pattern, MSB-first payload, optional parity, idle gap
// Build option: define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
    parameter int                GAP_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(((SYNC_W > DATA_W) ? SYNC_W : DATA_W) + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PAR,
        ST_GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;
`endif

    state_t            state;
    logic [SYNC_W-1:0] sync_sh;
    logic [DATA_W-1:0] data_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic              par_bit;
`endif

    assign in_ready = (state == ST_IDLE);

    // State names the bit currently on dout; bit_cnt counts bits of that field already sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sync_sh    <= '0;
            data_sh    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dout <= 1'b0;
                    if (in_valid) begin
                        // First sync bit leaves on the transfer edge itself.
                        state   <= ST_SYNC;
                        dout    <= SYNC_PAT[SYNC_W-1];
                        sync_sh <= SYNC_PAT << 1;
                        data_sh <= in_data;
                        bit_cnt <= CNT_W'(1);
                        busy    <= 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        par_bit <= ^in_data;
`endif
                    end
                end

                ST_SYNC: begin
                    if (bit_cnt == SYNC_LAST) begin
                        state   <= ST_DATA;
                        dout    <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= CNT_W'(1);
                    end else begin
                        dout    <= sync_sh[SYNC_W-1];
                        sync_sh <= sync_sh << 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state <= ST_PAR;
                        dout  <= par_bit;
`else
                        dout       <= 1'b0;
                        frame_done <= 1'b1;
                        if (GAP_CYC > 1) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_W'(1);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end else begin
                        dout    <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

`ifdef SEQ_FRAME_TX_PARITY_EN
                ST_PAR: begin
                    dout       <= 1'b0;
                    frame_done <= 1'b1;
                    if (GAP_CYC > 1) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_W'(1);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif

                // The IDLE cycle that follows supplies the last gap zero.
                ST_GAP: begin
                    dout <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
